// File: rtl/uba_intarb.sv
// uba_intarb: Unibus adapter interrupt arbiter.
//
// Collects up to four device interrupt requests and presents a single
// PI-level request to the backplane. When the CPU asks for a vector, it
// returns the vector of the latched device and pulses that device's
// acknowledge. A vector request with no interrupt pending is answered
// passively with a zero vector.
//
// Build option: define UBA_INTARB_RR_EN for round-robin arbitration.
// Without it, fixed priority applies (device 0 highest) and the
// round-robin pointer register does not exist.
//
// All outputs come straight from flops. A reset sampled on the edge
// that would start the acknowledge cycle therefore suppresses that
// acknowledge completely, and every output reads zero afterwards.

module uba_intarb #(
    parameter logic [17:0] VECT0 = 18'o000254,  // vector for device 0
    parameter logic [17:0] VECT1 = 18'o000224,  // vector for device 1
    parameter logic [17:0] VECT2 = 18'o000000,  // vector for device 2
    parameter logic [17:0] VECT3 = 18'o000000   // vector for device 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic [2:0]  ubaPIA,
    input  logic [3:0]  devIRQ,
    output logic [3:0]  devIACK,
    input  logic        busVECTREQ,
    output logic [6:0]  busINTR,
    output logic        busVECTACK,
    output logic [17:0] busVECT
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAck,
        StWait
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  dev_q,   dev_d;     // latched winning device
    logic [2:0]  pia_q,   pia_d;     // PI level latched when leaving IDLE
    logic [3:0]  iack_q,  iack_d;
    logic [6:0]  intr_q,  intr_d;
    logic        vack_q,  vack_d;
    logic [17:0] vect_q,  vect_d;

    logic [1:0]  win_idx;            // arbitration winner among devIRQ

`ifdef UBA_INTARB_RR_EN
    logic [1:0]  rr_q, rr_d;         // device searched first
    logic [1:0]  rr_cand;
    logic        rr_found;

    // Round-robin search starting at the pointer, wrapping 3 -> 0.
    always_comb begin
        win_idx  = 2'd0;
        rr_cand  = 2'd0;
        rr_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rr_cand = rr_q + 2'(k);
            if (!rr_found && devIRQ[rr_cand]) begin
                win_idx  = rr_cand;
                rr_found = 1'b1;
            end
        end
    end
`else
    // Fixed priority: lowest set index wins, so scan downwards.
    always_comb begin
        win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (devIRQ[i]) begin
                win_idx = 2'(i);
            end
        end
    end
`endif

    // Vector table lookup for a device index.
    function automatic logic [17:0] vect_of(input logic [1:0] idx);
        logic [17:0] v;
        unique case (idx)
            2'd0:    v = VECT0;
            2'd1:    v = VECT1;
            2'd2:    v = VECT2;
            default: v = VECT3;
        endcase
        return v;
    endfunction

    // Next-state and next-output decode; outputs default to zero so
    // every strobe lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        dev_d   = dev_q;
        pia_d   = pia_q;
        iack_d  = 4'd0;
        intr_d  = 7'd0;
        vack_d  = 1'b0;
        vect_d  = 18'd0;
`ifdef UBA_INTARB_RR_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (busVECTREQ) begin
                    // Vector read not aimed at us: passive zero-vector release.
                    vack_d  = 1'b1;
                    state_d = StWait;
                end else if ((devIRQ != 4'd0) && (ubaPIA != 3'd0)) begin
                    dev_d   = win_idx;
                    pia_d   = ubaPIA;
                    intr_d  = 7'b1 << (ubaPIA - 3'd1);
                    state_d = StReq;
                end
            end
            StReq: begin
                if ((ubaPIA == 3'd0) || !devIRQ[dev_q]) begin
                    // Request withdrawn or level disabled: re-arbitrate from IDLE.
                    state_d = StIdle;
                end else if (busVECTREQ) begin
                    vack_d  = 1'b1;
                    vect_d  = vect_of(dev_q);
                    iack_d  = 4'b0001 << dev_q;
                    state_d = StAck;
`ifdef UBA_INTARB_RR_EN
                    rr_d    = dev_q + 2'd1;
`endif
                end else begin
                    // Level stays on the latched PIA even if ubaPIA changes.
                    intr_d  = 7'b1 << (pia_q - 3'd1);
                end
            end
            StAck: begin
                state_d = StWait;
            end
            StWait: begin
                // Hold until the CPU drops its request so the device's
                // cleared IRQ is seen before the next arbitration.
                if (!busVECTREQ) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset from either source.
    always_ff @(posedge clk) begin
        if (rst || devRESET) begin
            state_q <= StIdle;
            dev_q   <= 2'd0;
            pia_q   <= 3'd0;
            iack_q  <= 4'd0;
            intr_q  <= 7'd0;
            vack_q  <= 1'b0;
            vect_q  <= 18'd0;
`ifdef UBA_INTARB_RR_EN
            rr_q    <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
            pia_q   <= pia_d;
            iack_q  <= iack_d;
            intr_q  <= intr_d;
            vack_q  <= vack_d;
            vect_q  <= vect_d;
`ifdef UBA_INTARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    assign devIACK    = iack_q;
    assign busINTR    = intr_q;
    assign busVECTACK = vack_q;
    assign busVECT    = vect_q;

endmodule

// File: tb/tb_uba_intarb.sv
// Testbench for uba_intarb: directed vector table, a few multi-cycle
// handshake sequences, then randomized stimulus against a reference model.
// Honours UBA_INTARB_RR_EN the same way the design does.

module tb_uba_intarb;

    localparam logic [17:0] V0 = 18'o000254;
    localparam logic [17:0] V1 = 18'o000224;
    localparam logic [17:0] V2 = 18'o000000;
    localparam logic [17:0] V3 = 18'o000000;

    logic        clk;
    logic        rst;
    logic        devRESET;
    logic [2:0]  ubaPIA;
    logic [3:0]  devIRQ;
    logic [3:0]  devIACK;
    logic        busVECTREQ;
    logic [6:0]  busINTR;
    logic        busVECTACK;
    logic [17:0] busVECT;

    int vectors;
    int miscompares;

    uba_intarb dut (
        .clk        (clk),
        .rst        (rst),
        .devRESET   (devRESET),
        .ubaPIA     (ubaPIA),
        .devIRQ     (devIRQ),
        .devIACK    (devIACK),
        .busVECTREQ (busVECTREQ),
        .busINTR    (busINTR),
        .busVECTACK (busVECTACK),
        .busVECT    (busVECT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2, P_WAIT = 3;
    int          m_phase, m_dev, m_pia, m_ptr;
    logic [3:0]  e_iack;
    logic [6:0]  e_intr;
    logic        e_vack;
    logic [17:0] e_vect;
    logic [17:0] vtab [4];

    function automatic int pick(input logic [3:0] irq, input int ptr);
        int start;
`ifdef UBA_INTARB_RR_EN
        start = ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (irq[(start + k) % 4]) return (start + k) % 4;
        end
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        e_iack = '0;
        e_intr = '0;
        e_vack = 1'b0;
        e_vect = '0;
        if (rst || devRESET) begin
            m_phase = P_IDLE;
            m_dev   = 0;
            m_pia   = 0;
            m_ptr   = 0;
            return;
        end
        case (m_phase)
            P_IDLE: begin
                if (busVECTREQ) begin
                    e_vack  = 1'b1;
                    m_phase = P_WAIT;
                end else if (devIRQ != 0 && ubaPIA != 0) begin
                    m_dev   = pick(devIRQ, m_ptr);
                    m_pia   = int'(ubaPIA);
                    e_intr  = 7'(1 << (m_pia - 1));
                    m_phase = P_REQ;
                end
            end
            P_REQ: begin
                if (ubaPIA == 0 || !devIRQ[m_dev]) begin
                    m_phase = P_IDLE;
                end else if (busVECTREQ) begin
                    e_vack  = 1'b1;
                    e_vect  = vtab[m_dev];
                    e_iack  = 4'(1 << m_dev);
                    m_ptr   = (m_dev + 1) % 4;
                    m_phase = P_ACK;
                end else begin
                    e_intr = 7'(1 << (m_pia - 1));
                end
            end
            P_ACK:   m_phase = P_WAIT;
            default: if (!busVECTREQ) m_phase = P_IDLE;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic dr, input logic [2:0] pia,
                         input logic [3:0] irq, input logic vreq);
        rst        = r;
        devRESET   = dr;
        ubaPIA     = pia;
        devIRQ     = irq;
        busVECTREQ = vreq;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic        dr;
        logic [2:0]  pia;
        logic [3:0]  irq;
        logic        vreq;
        logic [3:0]  x_iack;
        logic [6:0]  x_intr;
        logic        x_vack;
        logic [17:0] x_vect;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic dr, input logic [2:0] pia,
                                input logic [3:0] irq, input logic vreq,
                                input logic [3:0] xi, input logic [6:0] xn,
                                input logic xa, input logic [17:0] xv);
        vec_t v;
        v.r = r; v.dr = dr; v.pia = pia; v.irq = irq; v.vreq = vreq;
        v.x_iack = xi; v.x_intr = xn; v.x_vack = xa; v.x_vect = xv;
        tbl.push_back(v);
    endfunction

    // One full vector handshake with a bounded wait on each DUT event.
    task automatic vector_cycle(input string name, input logic [6:0] x_intr,
                                input logic [3:0] x_iack, input logic [17:0] x_vect);
        int n;
        n = 0;
        while (busINTR == 7'd0 && n < 8) begin
            tick();
            n++;
        end
        check({name, " intr"}, 32'(busINTR), 32'(x_intr));
        busVECTREQ = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!busVECTACK && n < 8);
        check({name, " ack"}, 32'(busVECTACK), 32'd1);
        check({name, " iack"}, 32'(devIACK), 32'(x_iack));
        check({name, " vect"}, 32'(busVECT), 32'(x_vect));
        tick();
        check({name, " iack one cycle"}, 32'(devIACK), 32'd0);
        busVECTREQ = 1'b0;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        vtab[0] = V0; vtab[1] = V1; vtab[2] = V2; vtab[3] = V3;
        m_phase = P_IDLE; m_dev = 0; m_pia = 0; m_ptr = 0;
        drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);

        //   r  dr  pia  irq      vreq  iack     intr         vack  vect
        add(1, 0, 3'd0, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);    // reset
        add(0, 0, 3'd5, 4'b0001, 0, 4'b0000, 7'b0010000, 0, 18'o0);    // dev0 at PI5
        add(0, 0, 3'd5, 4'b0001, 1, 4'b0001, 7'b0000000, 1, V0);       // one-clock ack
        add(0, 0, 3'd5, 4'b0001, 1, 4'b0000, 7'b0000000, 0, 18'o0);    // wait
        add(0, 0, 3'd5, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);    // idle
        add(0, 0, 3'd5, 4'b0110, 0, 4'b0000, 7'b0010000, 0, 18'o0);    // dev1 wins
        add(0, 0, 3'd5, 4'b0110, 1, 4'b0010, 7'b0000000, 1, V1);
        add(0, 0, 3'd5, 4'b0100, 1, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd5, 4'b0100, 0, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd5, 4'b0100, 0, 4'b0000, 7'b0010000, 0, 18'o0);    // dev2 next
        add(0, 0, 3'd5, 4'b0100, 1, 4'b0100, 7'b0000000, 1, V2);
        add(0, 0, 3'd5, 4'b0000, 1, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd5, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd3, 4'b0001, 0, 4'b0000, 7'b0000100, 0, 18'o0);    // REQ at PI3
        add(0, 0, 3'd3, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);    // IRQ withdrawn
        add(0, 0, 3'd3, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd2, 4'b1000, 0, 4'b0000, 7'b0000010, 0, 18'o0);    // dev3 at PI2
        add(0, 0, 3'd7, 4'b1000, 0, 4'b0000, 7'b0000010, 0, 18'o0);    // PIA change ignored
        add(0, 0, 3'd7, 4'b1000, 1, 4'b1000, 7'b0000000, 1, V3);
        add(0, 0, 3'd7, 4'b0000, 1, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd7, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd1, 4'b0010, 0, 4'b0000, 7'b0000001, 0, 18'o0);    // PI1, bit 0
        add(0, 0, 3'd0, 4'b0010, 0, 4'b0000, 7'b0000000, 0, 18'o0);    // PIA -> 0 drops REQ
        add(0, 0, 3'd0, 4'b0010, 0, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd0, 4'b1111, 0, 4'b0000, 7'b0000000, 0, 18'o0);    // disabled level
        add(0, 0, 3'd0, 4'b1111, 1, 4'b0000, 7'b0000000, 1, 18'o0);    // passive release
        add(0, 0, 3'd0, 4'b1111, 1, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd0, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd6, 4'b0001, 0, 4'b0000, 7'b0100000, 0, 18'o0);    // REQ at PI6
        add(1, 0, 3'd6, 4'b0001, 1, 4'b0000, 7'b0000000, 0, 18'o0);    // rst kills ack
        add(0, 0, 3'd6, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);
        add(0, 0, 3'd4, 4'b0100, 0, 4'b0000, 7'b0001000, 0, 18'o0);    // REQ at PI4
        add(0, 1, 3'd4, 4'b0100, 0, 4'b0000, 7'b0000000, 0, 18'o0);    // devRESET
        add(0, 0, 3'd4, 4'b0000, 0, 4'b0000, 7'b0000000, 0, 18'o0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].dr, tbl[i].pia, tbl[i].irq, tbl[i].vreq);
            tick();
            check($sformatf("row%0d iack", i), 32'(devIACK), 32'(tbl[i].x_iack));
            check($sformatf("row%0d intr", i), 32'(busINTR), 32'(tbl[i].x_intr));
            check($sformatf("row%0d vack", i), 32'(busVECTACK), 32'(tbl[i].x_vack));
            check($sformatf("row%0d vect", i), 32'(busVECT), 32'(tbl[i].x_vect));
        end

        // Three back-to-back vector cycles with devIRQ=0011 held level.
        drive(1'b0, 1'b0, 3'd5, 4'b0011, 1'b0);
`ifdef UBA_INTARB_RR_EN
        vector_cycle("grant1", 7'b0010000, 4'b0001, V0);
        vector_cycle("grant2", 7'b0010000, 4'b0010, V1);
        vector_cycle("grant3", 7'b0010000, 4'b0001, V0);
`else
        vector_cycle("grant1", 7'b0010000, 4'b0001, V0);
        vector_cycle("grant2", 7'b0010000, 4'b0001, V0);
        vector_cycle("grant3", 7'b0010000, 4'b0001, V0);
`endif

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 3'd0, 4'd0, 1'b0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            devRESET = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) ubaPIA = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) devIRQ = 4'($urandom);
            if ($urandom_range(0, 2) == 0) busVECTREQ = ~busVECTREQ;
            tick();
            check($sformatf("rnd%0d iack", c), 32'(devIACK), 32'(e_iack));
            check($sformatf("rnd%0d intr", c), 32'(busINTR), 32'(e_intr));
            check($sformatf("rnd%0d vack", c), 32'(busVECTACK), 32'(e_vack));
            check($sformatf("rnd%0d vect", c), 32'(busVECT), 32'(e_vect));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
